instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage feeding the main controller: owns the PC, issues word reads to instruction memory over a
//  req/gnt/rvalid handshake, holds the returned instruction for decode (op/funct/jump field) under a
//  valid/ready handshake, and applies the controller's pcsrc/jump redirect when that instruction retires.
//  Supports an asynchronous-to-pipeline flush (exception/restart) that discards in-flight reads.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC after reset; must be word aligned
//  CNT_W      32             width of retired-instruction counter
// PORTS
//  clk           in   1   single clock, rising edge
//  reset_n       in   1   asynchronous, active-low reset
//  imem_req      out  1   read request; held until imem_gnt
//  imem_addr     out  32  word-aligned read address (= pc while requesting)
//  imem_gnt      in   1   request accepted this cycle
//  imem_rvalid   in   1   read data valid (>= 0 cycles after gnt, may coincide with gnt)
//  imem_rdata    in   32  instruction word
//  instr_valid   out  1   instr/pc/pcplus4 valid for decode
//  instr_ready   in   1   decode/execute consumes instr this cycle (retire)
//  instr         out  32  held instruction
//  pc            out  32  address of held instruction
//  pcplus4       out  32  pc + 4
//  pcsrc         in   1   taken branch for retiring instr (valid only when instr_valid & instr_ready)
//  jump          in   1   jump for retiring instr (same qualification)
//  pcbranch      in   32  branch target from datapath
//  flush         in   1   abandon current fetch/held instr, restart at flush_pc
//  flush_pc      in   32  restart address (bits[1:0] ignored, forced 0)
//  retired_cnt   out  CNT_W  count of retire handshakes, wraps to 0
// BEHAVIOUR
//  Reset (reset_n=0, immediate): state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0 during
//   reset, discard=0, retired_cnt=0. First request asserts the cycle after reset_n deasserts.
//  FSM: FETCH: imem_req=1, imem_addr=pc. gnt&rvalid -> capture rdata, HOLD; gnt only -> WAIT.
//   WAIT: imem_req=0; rvalid -> capture, HOLD. HOLD: instr_valid=1; instr_ready -> update pc, FETCH.
//  At most one outstanding read. Fetch latency req->instr_valid = 1 cycle + memory latency.
//  Next PC at retire: jump ? {pcplus4[31:28],instr[25:0],2'b00} : pcsrc ? pcbranch : pcplus4.
//   jump has priority when both set. pcbranch[1:0] forced to 0. pcplus4 wraps modulo 2^32.
//  pcsrc/jump/pcbranch ignored unless instr_valid & instr_ready.
//  Flush (highest priority, overrides retire same cycle): pc<=flush_pc, instr_valid<=0, state<=FETCH,
//   retired_cnt not incremented. If a read is outstanding (WAIT, or FETCH with gnt this cycle and no
//   rvalid) set discard=1; next rvalid is dropped and clears discard; request for flush_pc waits
//   until discard=0. Flush in FETCH without gnt: request retargets next cycle (req held, addr changes).
//  Flush during discard: update pc only; discard stays set.
//  imem_addr stable and imem_req held while req&!gnt (except flush retarget).
//  retired_cnt += 1 on each instr_valid&instr_ready without flush; CNT_W-bit wrap.
//  rvalid outside WAIT/same-cycle-gnt and not discarding: ignored (protocol error, assertion in bench).
//  Mid-operation reset: all state returns to reset values immediately; pending read ignored.
// STRUCTURE
//  Shared package mips_pkg: ADDR_W=32, INSTR_W=32, fetch_state_t enum {FETCH,WAIT,HOLD},
//   jump-target field slices (JADDR_MSB=25).
//  One sub-module: next_pc_sel (combinational next-PC mux: pcplus4/pcbranch/jump target).
//  Remaining FSM, capture registers, discard flag and counter live in instr_fetch_unit.
// TESTING
//  1 Reset, zero-latency mem (gnt&rvalid same cycle), ready=1 -> addrs 0,4,8..; instr_valid 1 cycle
//    after each req; retired_cnt=3 after 3 retires.
//  2 Instr at pc=0x40 retires with pcsrc=1,pcbranch=0x100 -> next imem_addr=0x100; pcsrc=jump=1,
//    instr[25:0]=0x10 -> next imem_addr=0x40 (jump wins: {0x0,0x10,00}).
//  3 gnt low 3 cycles -> imem_req held, imem_addr constant; rvalid 2 cycles after gnt -> instr captured.
//  4 instr_ready low 5 cycles in HOLD -> instr/pc stable, no new imem_req, retired_cnt unchanged.
//  5 flush(flush_pc=0x200) in WAIT; rvalid next cycle with 0xDEADBEEF -> dropped, then req to 0x200,
//    instr_valid never shows 0xDEADBEEF.
//  6 reset_n low while in WAIT -> outputs at reset values same cycle; later rvalid ignored; pc=RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package : mips_pkg
// Shared widths, fetch FSM encoding and jump-target helper for the front end.
// Revision: 1.0
// ============================================================================
package mips_pkg;

   localparam int ADDR_W    = 32;
   localparam int INSTR_W   = 32;
   localparam int JADDR_MSB = 25;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   typedef enum logic [1:0] {
      FETCH = ST_FETCH,
      WAIT  = ST_WAIT,
      HOLD  = ST_HOLD
   } fetch_state_t;

   // J-type target: region bits of pc+4, 26-bit word index, word alignment
   function automatic logic [ADDR_W-1:0] jump_target(
      input logic [ADDR_W-1:0]  pcplus4,
      input logic [INSTR_W-1:0] instr
   );
      return {pcplus4[ADDR_W-1:JADDR_MSB+3], instr[JADDR_MSB:0], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/next_pc_sel.sv
`default_nettype none
// ============================================================================
// Module  : next_pc_sel
// Combinational next-PC select: jump target, branch target or pc+4.
// Revision: 1.0
// ============================================================================
module next_pc_sel
   import mips_pkg::*;
(
   input  logic [ADDR_W-1:0]  pcplus4,
   input  logic [INSTR_W-1:0] instr,
   input  logic               pcsrc,
   input  logic               jump,
   input  logic [ADDR_W-1:0]  pcbranch,
   output logic [ADDR_W-1:0]  pc_next
);

   always_comb begin
      pc_next = pcplus4;
      if (jump) begin
         pc_next = jump_target(pcplus4, instr);
      end else if (pcsrc) begin
         pc_next = {pcbranch[ADDR_W-1:2], 2'b00};
      end
   end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit
// Fetch stage: PC ownership, imem req/gnt/rvalid reads, decode hand-off, flush.
// Revision: 1.0
// ============================================================================
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int                CNT_W    = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  pc,
   output logic [ADDR_W-1:0]  pcplus4,
   input  logic               pcsrc,
   input  logic               jump,
   input  logic [ADDR_W-1:0]  pcbranch,
   input  logic               flush,
   input  logic [ADDR_W-1:0]  flush_pc,
   output logic [CNT_W-1:0]   retired_cnt
);

   fetch_state_t        r_state;
   logic [ADDR_W-1:0]   r_pc;
   logic [INSTR_W-1:0]  r_instr;
   logic                r_discard;
   logic                r_started;
   logic [CNT_W-1:0]    r_retired_cnt;

   logic                w_req;
   logic                w_retire;
   logic                w_miss_pending;
   logic [ADDR_W-1:0]   w_pcplus4;
   logic [ADDR_W-1:0]   w_pc_next;

   // r_started keeps the request low through reset and releases it one edge later
   assign w_req          = r_started && (r_state == FETCH) && !r_discard;
   assign w_retire       = (r_state == HOLD) && instr_ready && !flush;
   assign w_pcplus4      = r_pc + 32'd4;
   assign w_miss_pending = ((r_state == WAIT) || (w_req && imem_gnt)) && !imem_rvalid;

   next_pc_sel u_next_pc_sel (
      .pcplus4  (w_pcplus4),
      .instr    (r_instr),
      .pcsrc    (pcsrc),
      .jump     (jump),
      .pcbranch (pcbranch),
      .pc_next  (w_pc_next)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= FETCH;
         r_pc      <= RESET_PC;
         r_instr   <= '0;
         r_discard <= 1'b0;
         r_started <= 1'b0;
      end else begin
         r_started <= 1'b1;
         if (flush) begin
            r_pc    <= {flush_pc[ADDR_W-1:2], 2'b00};
            r_state <= FETCH;
            // a read already dropping keeps dropping until its data returns
            if (r_discard) begin
               r_discard <= !imem_rvalid;
            end else begin
               r_discard <= w_miss_pending;
            end
         end else if (r_discard) begin
            if (imem_rvalid) begin
               r_discard <= 1'b0;
            end
         end else begin
            case (r_state)
               FETCH: begin
                  if (w_req && imem_gnt) begin
                     if (imem_rvalid) begin
                        r_instr <= imem_rdata;
                        r_state <= HOLD;
                     end else begin
                        r_state <= WAIT;
                     end
                  end
               end
               WAIT: begin
                  if (imem_rvalid) begin
                     r_instr <= imem_rdata;
                     r_state <= HOLD;
                  end
               end
               HOLD: begin
                  if (instr_ready) begin
                     r_pc    <= w_pc_next;
                     r_state <= FETCH;
                  end
               end
               default: r_state <= FETCH;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_retired_cnt <= '0;
      end else if (w_retire) begin
         r_retired_cnt <= r_retired_cnt + CNT_W'(1);
      end
   end

   assign imem_req    = w_req;
   assign imem_addr   = r_pc;
   assign instr_valid = (r_state == HOLD);
   assign instr       = r_instr;
   assign pc          = r_pc;
   assign pcplus4     = w_pcplus4;
   assign retired_cnt = r_retired_cnt;

endmodule
`default_nettype wire
